// File: rtl/edge_relax_unit_pkg.sv
// edge_relax_unit_pkg: shared widths, lane count and memory-word field offsets.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package edge_relax_unit_pkg;
  localparam int ADDRESS_LEN         = 5;
  localparam int NODE_WEIGHT_BITSIZE = 7;
  localparam int MEMORYWORD_BITSIZE  = 12;
  localparam int NUM_LANES           = 4;

  // Memory word layout: {weight, predecessor}
  localparam int PRED_LSB   = 0;
  localparam int PRED_MSB   = ADDRESS_LEN - 1;
  localparam int WEIGHT_LSB = ADDRESS_LEN;
  localparam int WEIGHT_MSB = ADDRESS_LEN + NODE_WEIGHT_BITSIZE - 1;

  typedef logic [ADDRESS_LEN-1:0]         addr_t;
  typedef logic [NODE_WEIGHT_BITSIZE-1:0] weight_t;
  typedef logic [MEMORYWORD_BITSIZE-1:0]  word_t;
endpackage

// File: rtl/edge_relax_unit_relax_lane.sv
// relax_lane: saturating candidate add, strict compare against destination weight, word packing.
// Latency: purely combinational.
// Backpressure: none; the enclosing pipeline stage qualifies the result with i_vld.
module relax_lane
  import edge_relax_unit_pkg::*;
#(
  parameter weight_t INF_W = 7'h7F
) (
  input  logic    i_vld,
  input  addr_t   i_src,
  input  weight_t i_edge_w,
  input  weight_t i_w_i,
  input  weight_t i_w_j,
  output weight_t o_cand,
  output logic    o_relax,
  output word_t   o_pred
);
  logic [NODE_WEIGHT_BITSIZE:0] w_sum;

  assign w_sum = {1'b0, i_w_i} + {1'b0, i_edge_w};

  // Candidate distance; an unreachable source or any overflow past INF_W stays at INF_W
  always_comb begin
    o_cand = w_sum[NODE_WEIGHT_BITSIZE-1:0];
    if ((i_w_i == INF_W) || (w_sum >= {1'b0, INF_W})) begin
      o_cand = INF_W;
    end
  end

  assign o_relax = i_vld && (o_cand < i_w_j);

  // Pack the candidate weight above the predecessor node id
  always_comb begin
    o_pred = '0;
    o_pred[WEIGHT_MSB:WEIGHT_LSB] = o_cand;
    o_pred[PRED_MSB:PRED_LSB]     = i_src;
  end
endmodule

// File: rtl/edge_relax_unit.sv
// edge_relax_unit: 4-lane edge relaxation against an external register file (option macro RELAX_FWD_EN).
// Latency: beat captured in S1 at the accept edge; write port driven from S2 after the following edge.
// Backpressure: RELAX_FWD_EN forwards S2 write data, in_ready=1; otherwise in_ready drops for one cycle on an S1/S2 address match.
module edge_relax_unit
  import edge_relax_unit_pkg::*;
#(
  parameter weight_t INF_W = 7'h7F
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    in_valid,
  output logic    in_ready,
  input  logic    edge_vld0, edge_vld1, edge_vld2, edge_vld3,
  input  addr_t   edge_i0, edge_i1, edge_i2, edge_i3,
  input  addr_t   edge_j0, edge_j1, edge_j2, edge_j3,
  input  weight_t edge_w0, edge_w1, edge_w2, edge_w3,
  output addr_t   readaddr_i0, readaddr_i1, readaddr_i2, readaddr_i3,
  output addr_t   readaddr_j0, readaddr_j1, readaddr_j2, readaddr_j3,
  input  weight_t w_i0, w_i1, w_i2, w_i3,
  input  weight_t w_j0, w_j1, w_j2, w_j3,
  output addr_t   writeaddr_j0, writeaddr_j1, writeaddr_j2, writeaddr_j3,
  output word_t   w_j_pred0, w_j_pred1, w_j_pred2, w_j_pred3,
  output logic    wr_en0, wr_en1, wr_en2, wr_en3,
  output logic    relaxed,
  input  logic    clr_relaxed,
  output logic    busy
);
  logic    w_in_vld [NUM_LANES];
  addr_t   w_in_i   [NUM_LANES];
  addr_t   w_in_j   [NUM_LANES];
  weight_t w_in_w   [NUM_LANES];
  weight_t w_rd_wi  [NUM_LANES];
  weight_t w_rd_wj  [NUM_LANES];
  weight_t w_eff_wi [NUM_LANES];
  weight_t w_eff_wj [NUM_LANES];
  weight_t w_cand   [NUM_LANES];
  logic    w_relax  [NUM_LANES];
  logic    w_wr     [NUM_LANES];
  word_t   w_pred   [NUM_LANES];
  logic    w_stall;
  logic    w_any_wr;

  logic    r_s1_vld;
  logic    r_s1_lv  [NUM_LANES];
  addr_t   r_s1_i   [NUM_LANES];
  addr_t   r_s1_j   [NUM_LANES];
  weight_t r_s1_w   [NUM_LANES];
  logic    r_s2_vld;
  logic    r_s2_wr  [NUM_LANES];
  addr_t   r_s2_addr[NUM_LANES];
  word_t   r_s2_data[NUM_LANES];
  logic    r_relaxed;

  assign w_in_vld = '{edge_vld0, edge_vld1, edge_vld2, edge_vld3};
  assign w_in_i   = '{edge_i0, edge_i1, edge_i2, edge_i3};
  assign w_in_j   = '{edge_j0, edge_j1, edge_j2, edge_j3};
  assign w_in_w   = '{edge_w0, edge_w1, edge_w2, edge_w3};
  assign w_rd_wi  = '{w_i0, w_i1, w_i2, w_i3};
  assign w_rd_wj  = '{w_j0, w_j1, w_j2, w_j3};

`ifdef RELAX_FWD_EN
  // S2 is committing this cycle: substitute its weight for any stale register-file read
  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) begin
      w_eff_wi[k] = w_rd_wi[k];
      w_eff_wj[k] = w_rd_wj[k];
      for (int m = 0; m < NUM_LANES; m++) begin
        if (r_s2_wr[m] && (r_s2_addr[m] == r_s1_i[k])) begin
          w_eff_wi[k] = r_s2_data[m][WEIGHT_MSB:WEIGHT_LSB];
        end
        if (r_s2_wr[m] && (r_s2_addr[m] == r_s1_j[k])) begin
          w_eff_wj[k] = r_s2_data[m][WEIGHT_MSB:WEIGHT_LSB];
        end
      end
    end
  end
  assign w_stall = 1'b0;
`else
  // Hold S1 while any of its live reads targets a node S2 is about to commit
  always_comb begin
    w_stall = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      w_eff_wi[k] = w_rd_wi[k];
      w_eff_wj[k] = w_rd_wj[k];
      for (int m = 0; m < NUM_LANES; m++) begin
        if (r_s1_vld && r_s1_lv[k] && r_s2_wr[m] &&
            ((r_s2_addr[m] == r_s1_i[k]) || (r_s2_addr[m] == r_s1_j[k]))) begin
          w_stall = 1'b1;
        end
      end
    end
  end
`endif

  assign in_ready = !w_stall;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    relax_lane #(.INF_W(INF_W)) u_lane (
      .i_vld    (r_s1_vld && r_s1_lv[g]),
      .i_src    (r_s1_i[g]),
      .i_edge_w (r_s1_w[g]),
      .i_w_i    (w_eff_wi[g]),
      .i_w_j    (w_eff_wj[g]),
      .o_cand   (w_cand[g]),
      .o_relax  (w_relax[g]),
      .o_pred   (w_pred[g])
    );
  end

  // Same-destination lanes: only the lowest candidate writes, lower lane index wins a tie
  always_comb begin
    w_any_wr = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      w_wr[k] = w_relax[k];
      for (int m = 0; m < NUM_LANES; m++) begin
        if ((m != k) && w_relax[m] && (r_s1_j[m] == r_s1_j[k]) &&
            ((w_cand[m] < w_cand[k]) || ((w_cand[m] == w_cand[k]) && (m < k)))) begin
          w_wr[k] = 1'b0;
        end
      end
      w_any_wr = w_any_wr | (w_wr[k] && !w_stall);
    end
  end

  // S1 capture; lane fields only load on accept so read addresses hold while empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_vld <= 1'b0;
      for (int k = 0; k < NUM_LANES; k++) begin
        r_s1_lv[k] <= 1'b0;
        r_s1_i[k]  <= '0;
        r_s1_j[k]  <= '0;
        r_s1_w[k]  <= '0;
      end
    end else if (!w_stall) begin
      r_s1_vld <= in_valid;
      if (in_valid) begin
        for (int k = 0; k < NUM_LANES; k++) begin
          r_s1_lv[k] <= w_in_vld[k];
          r_s1_i[k]  <= w_in_i[k];
          r_s1_j[k]  <= w_in_j[k];
          r_s1_w[k]  <= w_in_w[k];
        end
      end
    end
  end

  // S2 write port; a stalled or empty S1 leaves a bubble with all enables low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_vld <= 1'b0;
      for (int k = 0; k < NUM_LANES; k++) begin
        r_s2_wr[k]   <= 1'b0;
        r_s2_addr[k] <= '0;
        r_s2_data[k] <= '0;
      end
    end else begin
      r_s2_vld <= r_s1_vld && !w_stall;
      for (int k = 0; k < NUM_LANES; k++) begin
        r_s2_wr[k] <= w_wr[k] && !w_stall;
        if (r_s1_vld && !w_stall) begin
          r_s2_addr[k] <= r_s1_j[k];
          r_s2_data[k] <= w_pred[k];
        end
      end
    end
  end

  // Sticky write indicator; a clear on the same edge beats a new set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_relaxed <= 1'b0;
    end else if (clr_relaxed) begin
      r_relaxed <= 1'b0;
    end else if (w_any_wr) begin
      r_relaxed <= 1'b1;
    end
  end

  assign relaxed = r_relaxed;
  assign busy    = r_s1_vld | r_s2_vld;

  assign readaddr_i0 = r_s1_i[0];
  assign readaddr_i1 = r_s1_i[1];
  assign readaddr_i2 = r_s1_i[2];
  assign readaddr_i3 = r_s1_i[3];
  assign readaddr_j0 = r_s1_j[0];
  assign readaddr_j1 = r_s1_j[1];
  assign readaddr_j2 = r_s1_j[2];
  assign readaddr_j3 = r_s1_j[3];

  assign writeaddr_j0 = r_s2_addr[0];
  assign writeaddr_j1 = r_s2_addr[1];
  assign writeaddr_j2 = r_s2_addr[2];
  assign writeaddr_j3 = r_s2_addr[3];
  assign w_j_pred0    = r_s2_data[0];
  assign w_j_pred1    = r_s2_data[1];
  assign w_j_pred2    = r_s2_data[2];
  assign w_j_pred3    = r_s2_data[3];
  assign wr_en0       = r_s2_wr[0];
  assign wr_en1       = r_s2_wr[1];
  assign wr_en2       = r_s2_wr[2];
  assign wr_en3       = r_s2_wr[3];
endmodule

// File: tb/tb_edge_relax_unit.sv
// tb_edge_relax_unit: register-file model around edge_relax_unit, sequential relaxation reference, write scoreboard.
// Latency: expected writes queued at issue, popped whenever any wr_en is seen.
// Backpressure: beats retried while in_ready is low, with a bounded wait.
module tb_edge_relax_unit;
  localparam logic [6:0] INF = 7'h7F;

  typedef struct packed {
    logic [3:0]  en;
    logic [19:0] a;
    logic [47:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0, clr_relaxed = 1'b0;
  logic in_ready, relaxed, busy;
  logic edge_vld0 = 0, edge_vld1 = 0, edge_vld2 = 0, edge_vld3 = 0;
  logic [4:0] edge_i0 = 0, edge_i1 = 0, edge_i2 = 0, edge_i3 = 0;
  logic [4:0] edge_j0 = 0, edge_j1 = 0, edge_j2 = 0, edge_j3 = 0;
  logic [6:0] edge_w0 = 0, edge_w1 = 0, edge_w2 = 0, edge_w3 = 0;
  logic [4:0] readaddr_i0, readaddr_i1, readaddr_i2, readaddr_i3;
  logic [4:0] readaddr_j0, readaddr_j1, readaddr_j2, readaddr_j3;
  logic [6:0] w_i0, w_i1, w_i2, w_i3, w_j0, w_j1, w_j2, w_j3;
  logic [4:0] writeaddr_j0, writeaddr_j1, writeaddr_j2, writeaddr_j3;
  logic [11:0] w_j_pred0, w_j_pred1, w_j_pred2, w_j_pred3;
  logic wr_en0, wr_en1, wr_en2, wr_en3;

  logic [6:0] rf_w [32];
  logic [4:0] rf_p [32];
  logic [6:0] model_w [32];
  logic [4:0] model_p [32];
  logic       model_relaxed = 1'b0;
  exp_t       exp_q [$];
  logic       init_en = 1'b0;
  logic [4:0] init_addr = '0;
  logic [6:0] init_val = '0;
  bit         mon_en = 1'b0;
  int         checks = 0;
  int         errors = 0;

  edge_relax_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .edge_vld0(edge_vld0), .edge_vld1(edge_vld1), .edge_vld2(edge_vld2), .edge_vld3(edge_vld3),
    .edge_i0(edge_i0), .edge_i1(edge_i1), .edge_i2(edge_i2), .edge_i3(edge_i3),
    .edge_j0(edge_j0), .edge_j1(edge_j1), .edge_j2(edge_j2), .edge_j3(edge_j3),
    .edge_w0(edge_w0), .edge_w1(edge_w1), .edge_w2(edge_w2), .edge_w3(edge_w3),
    .readaddr_i0(readaddr_i0), .readaddr_i1(readaddr_i1), .readaddr_i2(readaddr_i2), .readaddr_i3(readaddr_i3),
    .readaddr_j0(readaddr_j0), .readaddr_j1(readaddr_j1), .readaddr_j2(readaddr_j2), .readaddr_j3(readaddr_j3),
    .w_i0(w_i0), .w_i1(w_i1), .w_i2(w_i2), .w_i3(w_i3),
    .w_j0(w_j0), .w_j1(w_j1), .w_j2(w_j2), .w_j3(w_j3),
    .writeaddr_j0(writeaddr_j0), .writeaddr_j1(writeaddr_j1), .writeaddr_j2(writeaddr_j2), .writeaddr_j3(writeaddr_j3),
    .w_j_pred0(w_j_pred0), .w_j_pred1(w_j_pred1), .w_j_pred2(w_j_pred2), .w_j_pred3(w_j_pred3),
    .wr_en0(wr_en0), .wr_en1(wr_en1), .wr_en2(wr_en2), .wr_en3(wr_en3),
    .relaxed(relaxed), .clr_relaxed(clr_relaxed), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register file: combinational reads, writes commit on the edge after wr_en is presented
  assign w_i0 = rf_w[readaddr_i0];
  assign w_i1 = rf_w[readaddr_i1];
  assign w_i2 = rf_w[readaddr_i2];
  assign w_i3 = rf_w[readaddr_i3];
  assign w_j0 = rf_w[readaddr_j0];
  assign w_j1 = rf_w[readaddr_j1];
  assign w_j2 = rf_w[readaddr_j2];
  assign w_j3 = rf_w[readaddr_j3];

  always @(posedge clk) begin
    if (init_en) rf_w[init_addr] <= init_val;
    if (wr_en0) begin rf_w[writeaddr_j0] <= w_j_pred0[11:5]; rf_p[writeaddr_j0] <= w_j_pred0[4:0]; end
    if (wr_en1) begin rf_w[writeaddr_j1] <= w_j_pred1[11:5]; rf_p[writeaddr_j1] <= w_j_pred1[4:0]; end
    if (wr_en2) begin rf_w[writeaddr_j2] <= w_j_pred2[11:5]; rf_p[writeaddr_j2] <= w_j_pred2[4:0]; end
    if (wr_en3) begin rf_w[writeaddr_j3] <= w_j_pred3[11:5]; rf_p[writeaddr_j3] <= w_j_pred3[4:0]; end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every cycle that presents a write must match the oldest outstanding expected beat
  logic [3:0]  got_en;
  logic [19:0] got_a;
  logic [47:0] got_d;
  exp_t        mon_e;
  always @(negedge clk) begin
    if (rst && mon_en) begin
      got_en = {wr_en3, wr_en2, wr_en1, wr_en0};
      got_a  = {writeaddr_j3, writeaddr_j2, writeaddr_j1, writeaddr_j0};
      got_d  = {w_j_pred3, w_j_pred2, w_j_pred1, w_j_pred0};
      if (got_en != 4'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {28'b0, got_en}, 32'b0);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_mask", {28'b0, got_en}, {28'b0, mon_e.en});
          for (int k = 0; k < 4; k++) begin
            if (mon_e.en[k] && got_en[k]) begin
              check("wr_addr", {27'b0, got_a[k*5+:5]}, {27'b0, mon_e.a[k*5+:5]});
              check("wr_pred", {20'b0, got_d[k*12+:12]}, {20'b0, mon_e.d[k*12+:12]});
            end
          end
        end
      end
    end
  end

  // Reference: each beat reads the graph as left by all earlier beats, then applies its winners
  task automatic model_beat(input logic [3:0] v, input logic [19:0] ii, input logic [19:0] jj, input logic [27:0] ww);
    int   cand [4];
    bit   rel  [4];
    int   best;
    int   sum;
    exp_t e;
    e = '0;
    for (int k = 0; k < 4; k++) begin
      rel[k] = 0;
      cand[k] = INF;
      if (v[k]) begin
        sum = int'(model_w[ii[k*5+:5]]) + int'(ww[k*7+:7]);
        cand[k] = (model_w[ii[k*5+:5]] == INF || sum >= int'(INF)) ? int'(INF) : sum;
        rel[k] = cand[k] < int'(model_w[jj[k*5+:5]]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (rel[k]) begin
        best = -1;
        for (int m = 0; m < 4; m++)
          if (rel[m] && jj[m*5+:5] == jj[k*5+:5] && (best < 0 || cand[m] < cand[best])) best = m;
        if (best == k) begin
          e.en[k] = 1'b1;
          e.a[k*5+:5] = jj[k*5+:5];
          e.d[k*12+:12] = {cand[k][6:0], ii[k*5+:5]};
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (e.en[k]) begin
        model_w[jj[k*5+:5]] = cand[k][6:0];
        model_p[jj[k*5+:5]] = ii[k*5+:5];
      end
    end
    if (e.en != 4'b0) begin
      exp_q.push_back(e);
      model_relaxed = 1'b1;
    end
  endtask

  task automatic send_beat(input logic [3:0] v, input logic [19:0] ii, input logic [19:0] jj,
                           input logic [27:0] ww, input bit use_model, output int stalls);
    bit done;
    if (use_model) model_beat(v, ii, jj, ww);
    in_valid = 1'b1;
    {edge_vld3, edge_vld2, edge_vld1, edge_vld0} = v;
    {edge_i3, edge_i2, edge_i1, edge_i0} = ii;
    {edge_j3, edge_j2, edge_j1, edge_j0} = jj;
    {edge_w3, edge_w2, edge_w1, edge_w0} = ww;
    stalls = 0;
    done = 0;
    for (int t = 0; t < 16 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end else begin
        stalls++;
      end
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic set_node(input logic [4:0] a, input logic [6:0] val);
    @(negedge clk);
    init_en = 1'b1; init_addr = a; init_val = val;
    @(posedge clk);
    #1;
    init_en = 1'b0;
    model_w[a] = val;
  endtask

  task automatic drain();
    bit idle;
    idle = 0;
    for (int t = 0; t < 20 && !idle; t++) begin
      @(posedge clk);
      #1;
      idle = !busy;
    end
    if (!idle) check("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_relaxed = 1'b1;
    @(posedge clk);
    #1;
    clr_relaxed = 1'b0;
    model_relaxed = 1'b0;
  endtask

  int st;
  logic [3:0]  rv;
  logic [19:0] ri, rj;
  logic [27:0] rw;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_relaxed", {31'b0, relaxed}, 32'd0);
    check("rst_wr_en", {28'b0, wr_en3, wr_en2, wr_en1, wr_en0}, 32'd0);
    check("rst_readaddr", {12'b0, readaddr_i0, readaddr_i3, readaddr_j0, readaddr_j3}, 32'd0);
    check("rst_wr_data", {15'b0, writeaddr_j0, w_j_pred0}, 32'd0);
    for (int n = 0; n < 32; n++) begin
      set_node(n[4:0], INF);
      rf_p[n] = '0;
      model_p[n] = '0;
    end
    mon_en = 1'b1;

    // Basic relaxation: 0 (w=0) -> 1 (INF) with weight 5
    set_node(5'd0, 7'd0);
    send_beat(4'b0001, {15'd0, 5'd0}, {15'd0, 5'd1}, {21'd0, 7'd5}, 1'b1, st);
    check("t1_busy", {31'b0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check("t1_wr_en0", {31'b0, wr_en0}, 32'd1);
    check("t1_waddr0", {27'b0, writeaddr_j0}, 32'd1);
    check("t1_pred0", {20'b0, w_j_pred0}, {20'b0, 12'b0000101_00000});
    check("t1_relaxed", {31'b0, relaxed}, 32'd1);
    drain();

    // Equal candidate does not write; relaxed stays set
    set_node(5'd2, 7'd10);
    send_beat(4'b0001, {15'd0, 5'd0}, {15'd0, 5'd2}, {21'd0, 7'd10}, 1'b1, st);
    @(posedge clk);
    #1;
    check("t2_no_write", {31'b0, wr_en0}, 32'd0);
    drain();
    check("t2_relaxed_kept", {31'b0, relaxed}, 32'd1);
    pulse_clr();
    check("clr_relaxed", {31'b0, relaxed}, 32'd0);

    // Saturation: 120 + 20 clamps to INF, no write to an INF node
    set_node(5'd3, 7'd120);
    send_beat(4'b0001, {15'd0, 5'd3}, {15'd0, 5'd4}, {21'd0, 7'd20}, 1'b1, st);
    @(posedge clk);
    #1;
    check("t3_sat_no_write", {31'b0, wr_en0}, 32'd0);
    drain();
    check("t3_relaxed_clear", {31'b0, relaxed}, 32'd0);

    // Conflict: lanes 0 (0->5 w9) and 2 (1->5 w4) both give 9; lane 0 wins
    send_beat(4'b0101, {5'd0, 5'd1, 5'd0, 5'd0}, {5'd0, 5'd5, 5'd0, 5'd5},
              {7'd0, 7'd4, 7'd0, 7'd9}, 1'b1, st);
    @(posedge clk);
    #1;
    check("t4_mask", {28'b0, wr_en3, wr_en2, wr_en1, wr_en0}, 32'd1);
    check("t4_pred0", {20'b0, w_j_pred0}, {20'b0, 7'd9, 5'd0});
    drain();

    // Back-to-back dependency on node 1
    set_node(5'd1, INF);
    set_node(5'd6, INF);
    send_beat(4'b0001, {15'd0, 5'd0}, {15'd0, 5'd1}, {21'd0, 7'd5}, 1'b1, st);
    send_beat(4'b0011, {10'd0, 5'd0, 5'd1}, {10'd0, 5'd1, 5'd6}, {14'd0, 7'd5, 7'd3}, 1'b1, st);
    @(negedge clk);
`ifdef RELAX_FWD_EN
    check("t5_in_ready_fwd", {31'b0, in_ready}, 32'd1);
`else
    check("t5_in_ready_stall", {31'b0, in_ready}, 32'd0);
`endif
    @(negedge clk);
    check("t5_in_ready_after", {31'b0, in_ready}, 32'd1);
    drain();
    check("t5_node6", {25'b0, rf_w[6]}, 32'd8);
    check("t5_node1", {25'b0, rf_w[1]}, 32'd5);

    // Reset with S1 and S2 both occupied: nothing may commit
    set_node(5'd7, INF);
    set_node(5'd8, INF);
    send_beat(4'b0001, {15'd0, 5'd0}, {15'd0, 5'd7}, {21'd0, 7'd1}, 1'b0, st);
    send_beat(4'b0001, {15'd0, 5'd0}, {15'd0, 5'd8}, {21'd0, 7'd2}, 1'b0, st);
    check("t6_busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("t6_busy_rst", {31'b0, busy}, 32'd0);
    check("t6_wr_rst", {28'b0, wr_en3, wr_en2, wr_en1, wr_en0}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_relaxed = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("t6_wr_after", {28'b0, wr_en3, wr_en2, wr_en1, wr_en0}, 32'd0);
    end
    check("t6_busy_after", {31'b0, busy}, 32'd0);
    check("t6_relaxed_after", {31'b0, relaxed}, 32'd0);
    check("t6_node7", {25'b0, rf_w[7]}, {25'b0, INF});

    // Randomized bursts over a small node set to provoke conflicts and hazards
    for (int n = 0; n < 10; n++) set_node(n[4:0], ($urandom_range(0, 3) == 0) ? INF : 7'($urandom_range(0, 60)));
    pulse_clr();
    for (int b = 0; b < 300; b++) begin
      rv = 4'($urandom);
      for (int k = 0; k < 4; k++) begin
        ri[k*5+:5] = 5'($urandom_range(0, 9));
        rj[k*5+:5] = 5'($urandom_range(0, 9));
        rw[k*7+:7] = 7'($urandom_range(0, 40));
      end
      send_beat(rv, ri, rj, rw, 1'b1, st);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      if (b % 60 == 59) begin
        drain();
        for (int n = 0; n < 10; n++) set_node(n[4:0], 7'($urandom_range(20, 127)));
      end
    end
    drain();
    check("final_queue_empty", exp_q.size(), 32'd0);
    check("final_relaxed", {31'b0, relaxed}, {31'b0, model_relaxed});
    for (int n = 0; n < 32; n++) begin
      check("final_rf_w", {25'b0, rf_w[n]}, {25'b0, model_w[n]});
      check("final_rf_p", {27'b0, rf_p[n]}, {27'b0, model_p[n]});
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
